// File: rtl/hmac_pkg.sv
// hmac_pkg: shared encodings and helpers for the HMAC control sequencer
package hmac_pkg;
  typedef enum logic [2:0] {IDLE, IKEY, IMSG, OKEY, OMSG, DRAIN} state_t;
  typedef enum logic [1:0] {STG_IKEY, STG_IMSG, STG_OKEY, STG_OMSG} stage_t;
  typedef enum logic [1:0] {W_KEY, W_MSG, W_FB, W_PAD} wsel_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/hmac_pad_gen.sv
// hmac_pad_gen: SHA padding bit at a message bit position
// pos: bit position in padded message; len: payload bits; total: padded bits;
// field: 64-bit length value; pad_bit: generated padding/length bit
module hmac_pad_gen (
  input  logic [31:0] pos,
  input  logic [31:0] len,
  input  logic [31:0] total,
  input  logic [63:0] field,
  output logic        pad_bit
);
  logic [5:0] off;
  assign off = 6'(pos - (total - 32'd64));
  // ~off selects field bit 63-off, i.e. the length field MSB-first
  assign pad_bit = (pos == len) ? 1'b1 : (pos >= total - 32'd64) ? field[~off] : 1'b0;
endmodule

// File: rtl/hmac_sequencer.sv
// hmac_sequencer: self-timed stage/round/step schedule for the bit-serial HMAC datapath
// clk/rst_n: clock, async active-low reset; en: advance enable; start: begin in IDLE
// busy/done: handshake; stage/round/step/blk: schedule position; chain_init: load IV
// w_sel/pad_bit: schedule bit source; key_req/msg_req/bit_idx: input bit requests
// dig_valid: digest drain window
module hmac_sequencer import hmac_pkg::*; #(
  parameter int WORD_BITS  = 32,
  parameter int ROUNDS     = 80,
  parameter int HASH_WORDS = 5,
  parameter int MSG_BITS   = 64
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 en,
  input  logic                                                 start,
  output logic                                                 busy,
  output logic                                                 done,
  output logic [1:0]                                           stage,
  output logic [clog2(ROUNDS)-1:0]                             round,
  output logic [clog2(WORD_BITS)-1:0]                          step,
  output logic [clog2((MSG_BITS+64)/(16*WORD_BITS)+2)-1:0]     blk,
  output logic                                                 chain_init,
  output logic [1:0]                                           w_sel,
  output logic                                                 pad_bit,
  output logic                                                 key_req,
  output logic                                                 msg_req,
  output logic [15:0]                                          bit_idx,
  output logic                                                 dig_valid
);
  localparam int BLK_BITS  = 16*WORD_BITS;
  localparam int IN_BLOCKS = (MSG_BITS+64)/BLK_BITS + 1;
  localparam int IN_LEN    = BLK_BITS + MSG_BITS;
  localparam int DIG_BITS  = HASH_WORDS*WORD_BITS;
  localparam int OUT_LEN   = BLK_BITS + DIG_BITS;
  localparam int RW = clog2(ROUNDS);
  localparam int SW = clog2(WORD_BITS);
  localparam int BW = clog2(IN_BLOCKS+1);
  state_t state, state_n;
  logic [RW-1:0] round_n;
  logic [SW-1:0] step_n;
  logic [BW-1:0] blk_n;
  logic last_step, blk_end, drn_end, sched, is_msg, msgb, pg;
  logic [15:0] p;
  logic [31:0] g;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      round <= '0;
      step  <= '0;
      blk   <= '0;
    end else begin
      state <= state_n;
      round <= round_n;
      step  <= step_n;
      blk   <= blk_n;
    end
  // drain reuses round/step as its cycle counter
  always_comb begin
    state_n   = state;
    round_n   = round;
    step_n    = step;
    blk_n     = blk;
    last_step = step == SW'(WORD_BITS-1);
    blk_end   = last_step && round == RW'(ROUNDS-1);
    drn_end   = last_step && round == RW'(HASH_WORDS-1);
    if (en && state == IDLE) state_n = start ? IKEY : IDLE;
    else if (en) begin
      step_n  = last_step ? '0 : step + 1'b1;
      round_n = ((state == DRAIN) ? drn_end : blk_end) ? '0 : last_step ? round + 1'b1 : round;
      if (state == DRAIN && drn_end) state_n = IDLE;
      else if (state != DRAIN && blk_end) begin
        state_n = state == IKEY ? IMSG :
                  state == IMSG ? ((blk == BW'(IN_BLOCKS-1)) ? OKEY : IMSG) :
                  state == OKEY ? OMSG : DRAIN;
        blk_n   = (state == IMSG && blk != BW'(IN_BLOCKS-1)) ? blk + 1'b1 : '0;
      end
    end
  end
  // only rounds below 16 take external schedule bits; later rounds expand internally
  always_comb begin
    p          = 16'(round) * 16'(WORD_BITS) + 16'(step);
    g          = 32'(blk) * 32'(BLK_BITS) + 32'(p);
    sched      = 32'(round) < 32'd16;
    is_msg     = state == IMSG;
    key_req    = sched && (state == IKEY || state == OKEY);
    msgb       = sched && is_msg && g < 32'(MSG_BITS);
    msg_req    = msgb;
    bit_idx    = key_req ? p : msgb ? g[15:0] : '0;
    w_sel      = !sched ? W_KEY : is_msg ? (msgb ? W_MSG : W_PAD) :
                 state == OMSG ? ((32'(p) < 32'(DIG_BITS)) ? W_FB : W_PAD) : W_KEY;
    pad_bit    = w_sel == W_PAD && pg;
    stage      = is_msg ? STG_IMSG : state == OKEY ? STG_OKEY :
                 (state == OMSG || state == DRAIN) ? STG_OMSG : STG_IKEY;
    chain_init = state == IKEY || state == OKEY;
    dig_valid  = state == DRAIN;
    done       = dig_valid && drn_end;
    busy       = state != IDLE && !done;
  end
  hmac_pad_gen u_pad (
    .pos    (is_msg ? g : 32'(p)),
    .len    (is_msg ? 32'(MSG_BITS) : 32'(DIG_BITS)),
    .total  (is_msg ? 32'(IN_BLOCKS*BLK_BITS) : 32'(BLK_BITS)),
    .field  (is_msg ? 64'(IN_LEN) : 64'(OUT_LEN)),
    .pad_bit(pg)
  );
endmodule
